// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master.
// Requesters use a REQ/ACK handshake; the winner's command is run through the
// APB SETUP/ACCESS sequence, and read data plus a one-cycle ACK are returned.
// Optional macro APB_ARB_TIMEOUT_EN adds an ACCESS-phase wait limit that
// aborts the transfer with ACK+ERR once TIMEOUT_CYCLES wait cycles elapse.
module apb_master_arbiter #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic              WRITE0,
  input  logic [DATA_W-1:0] WDATA0,
  output logic              ACK0,
  output logic [DATA_W-1:0] RDATA0,
  output logic              ERR0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic              WRITE1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA1,
  output logic              ERR1,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  output logic              BUSY,
  output logic              GRANT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [1:0]          ack_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic                busy_q;
  logic                grant_q;   // also serves as the last-grant register

  logic                req_any;
  logic                win_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                write_d;
  logic [DATA_W-1:0]   wdata_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]    wait_q;
  logic [1:0]          err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Round-robin pick and mux of the winner's command fields.
  always_comb begin
    req_any = REQ0 | REQ1;
    win_d   = grant_q;
    if (REQ0 && REQ1) begin
      win_d = ~grant_q;
    end else if (REQ0) begin
      win_d = 1'b0;
    end else if (REQ1) begin
      win_d = 1'b1;
    end
    addr_d  = win_d ? ADDR1  : ADDR0;
    write_d = win_d ? WRITE1 : WRITE0;
    wdata_d = win_d ? WDATA1 : WDATA0;
  end

  // Arbitration / APB sequencing FSM with all outputs registered.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      busy_q    <= 1'b0;
      grant_q   <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
      wait_q    <= '0;
      err_q     <= '0;
`endif
    end else begin
      ack_q <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      err_q <= '0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          // A completion pulse in flight forces one dead cycle before sampling.
          if ((ack_q == 2'b00) && req_any) begin
            grant_q  <= win_d;
            paddr_q  <= addr_d;
            pwrite_q <= write_d;
            pwdata_q <= wdata_d;
            psel_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          wait_q    <= '0;
`endif
        end
        ST_ACCESS: begin
          if (PREADY) begin
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            busy_q         <= 1'b0;
            ack_q[grant_q] <= 1'b1;
            state_q        <= ST_IDLE;
            if (!pwrite_q) begin
              if (grant_q) rdata1_q <= PRDATA;
              else         rdata0_q <= PRDATA;
            end
`ifdef APB_ARB_TIMEOUT_EN
          end else if (wait_q == WAIT_LIM) begin
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            busy_q         <= 1'b0;
            ack_q[grant_q] <= 1'b1;
            err_q[grant_q] <= 1'b1;
            state_q        <= ST_IDLE;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign ACK0    = ack_q[0];
  assign ACK1    = ack_q[1];
  assign RDATA0  = rdata0_q;
  assign RDATA1  = rdata1_q;
  assign BUSY    = busy_q;
  assign GRANT   = grant_q;
`ifdef APB_ARB_TIMEOUT_EN
  assign ERR0    = err_q[0];
  assign ERR1    = err_q[1];
`else
  assign ERR0    = 1'b0;
  assign ERR1    = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed testbench for apb_master_arbiter.
// The timeout section is active only when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [4:0] ADDR0 = '0, ADDR1 = '0;
  logic       WRITE0 = 1'b0, WRITE1 = 1'b0;
  logic [7:0] WDATA0 = '0, WDATA1 = '0;
  logic       ACK0, ACK1, ERR0, ERR1;
  logic [7:0] RDATA0, RDATA1;
  logic       PSEL, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = '0;
  logic       PREADY = 1'b1;
  logic       BUSY, GRANT;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  apb_master_arbiter #(.ADDR_W(5), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ0(REQ0), .ADDR0(ADDR0), .WRITE0(WRITE0), .WDATA0(WDATA0),
    .ACK0(ACK0), .RDATA0(RDATA0), .ERR0(ERR0),
    .REQ1(REQ1), .ADDR1(ADDR1), .WRITE1(WRITE1), .WDATA1(WDATA1),
    .ACK1(ACK1), .RDATA1(RDATA1), .ERR1(ERR1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .BUSY(BUSY), .GRANT(GRANT)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apply_reset();
    PRESET = 1'b1;
    step();
    step();
    PRESET = 1'b0;
  endtask

  initial begin
    apply_reset();
    check_val("rst_psel",    PSEL,    0);
    check_val("rst_penable", PENABLE, 0);
    check_val("rst_busy",    BUSY,    0);
    check_val("rst_grant",   GRANT,   1);
    check_val("rst_paddr",   PADDR,   0);
    check_val("rst_pwdata",  PWDATA,  0);
    check_val("rst_acks",    {ACK1, ACK0, ERR1, ERR0}, 0);
    check_val("rst_rdata",   {RDATA1, RDATA0}, 0);

    // Zero-wait read by requester 0.
    REQ0 = 1'b1; ADDR0 = 5'h03; WRITE0 = 1'b0; PRDATA = 8'hA5; PREADY = 1'b1;
    step();
    check_val("t1_setup_psel",    PSEL,    1);
    check_val("t1_setup_penable", PENABLE, 0);
    check_val("t1_setup_paddr",   PADDR,   5'h03);
    check_val("t1_setup_grant",   GRANT,   0);
    check_val("t1_setup_busy",    BUSY,    1);
    step();
    check_val("t1_access_penable", PENABLE, 1);
    check_val("t1_access_psel",    PSEL,    1);
    check_val("t1_access_ack",     ACK0,    0);
    step();
    check_val("t1_ack0",   ACK0,   1);
    check_val("t1_ack1",   ACK1,   0);
    check_val("t1_rdata0", RDATA0, 8'hA5);
    check_val("t1_rdata1", RDATA1, 8'h00);
    check_val("t1_psel",   PSEL,   0);
    REQ0 = 1'b0;
    step();
    check_val("t1_dead_ack", ACK0, 0);
    check_val("t1_dead_psel", PSEL, 0);

    // Simultaneous writes after reset: grants alternate starting with 0.
    apply_reset();
    REQ0 = 1'b1; WRITE0 = 1'b1; WDATA0 = 8'h11; ADDR0 = 5'h01;
    REQ1 = 1'b1; WRITE1 = 1'b1; WDATA1 = 8'h22; ADDR1 = 5'h02;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_wd;
      logic       exp_g;
      exp_g  = (k % 2 == 1);
      exp_wd = exp_g ? 8'h22 : 8'h11;
      step();
      check_val($sformatf("t2_grant%0d", k),  GRANT,  exp_g);
      check_val($sformatf("t2_pwdata%0d", k), PWDATA, exp_wd);
      check_val($sformatf("t2_psel%0d", k),   PSEL,   1);
      step();
      step();
      check_val($sformatf("t2_acks%0d", k), {ACK1, ACK0}, exp_g ? 2'b10 : 2'b01);
      if (k == 3) begin
        REQ0 = 1'b0;
        REQ1 = 1'b0;
      end
      step();
      check_val($sformatf("t2_dead%0d", k), {PSEL, ACK1, ACK0}, 0);
    end
    check_val("t2_rdata_untouched", {RDATA1, RDATA0}, 0);

    // Requester 1 write with three wait states.
    REQ1 = 1'b1; ADDR1 = 5'h00; WRITE1 = 1'b1; WDATA1 = 8'h5A; PREADY = 1'b0;
    step();
    check_val("t3_grant", GRANT, 1);
    step();
    for (int w = 0; w < 3; w++) begin
      step();
      check_val($sformatf("t3_hold%0d", w), {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                {1'b1, 1'b1, 1'b1, 5'h00, 8'h5A});
      check_val($sformatf("t3_noack%0d", w), ACK1, 0);
    end
    PREADY = 1'b1;
    step();
    check_val("t3_ack1",   ACK1,   1);
    check_val("t3_err1",   ERR1,   0);
    check_val("t3_psel",   PSEL,   0);
    check_val("t3_rdata1", RDATA1, 0);
    REQ1 = 1'b0;
    step();
    check_val("t3_dead", ACK1, 0);

    // Reset asserted while in ACCESS.
    REQ0 = 1'b1; ADDR0 = 5'h0A; WRITE0 = 1'b0; PREADY = 1'b0;
    step();
    step();
    check_val("t4_in_access", PENABLE, 1);
    #2 PRESET = 1'b1;
    #1;
    check_val("t4_async_drop", {PSEL, PENABLE, BUSY}, 0);
    check_val("t4_no_ack",     ACK0,  0);
    check_val("t4_grant_rst",  GRANT, 1);
    REQ0 = 1'b0;
    step();
    step();
    PRESET = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b1; ADDR1 = 5'h1F; WRITE1 = 1'b0;
    PRDATA = 8'h5C; PREADY = 1'b1;
    step();
    check_val("t4_grant0", GRANT, 0);
    check_val("t4_paddr",  PADDR, 5'h0A);
    step();
    step();
    check_val("t4_acks",   {ACK1, ACK0}, 2'b01);
    check_val("t4_rdata0", RDATA0, 8'h5C);
    REQ0 = 1'b0; REQ1 = 1'b0;
    step();

    // REQ0 withdrawn during SETUP: transfer still completes.
    REQ0 = 1'b1; ADDR0 = 5'h07; WRITE0 = 1'b1; WDATA0 = 8'h3C; PREADY = 1'b1;
    step();
    REQ0 = 1'b0;
    check_val("t5_setup", {PSEL, PENABLE}, 2'b10);
    step();
    step();
    check_val("t5_ack0", ACK0, 1);
    step();
    step();
    step();
    check_val("t5_idle", {PSEL, BUSY, ACK0, ACK1}, 0);
    check_val("t5_rdata0_kept", RDATA0, 8'h5C);

`ifdef APB_ARB_TIMEOUT_EN
    // Stuck slave: abort after the wait limit.
    REQ0 = 1'b1; ADDR0 = 5'h04; WRITE0 = 1'b0; PRDATA = 8'hEE; PREADY = 1'b0;
    step();
    step();
    for (int w = 0; w < 4; w++) begin
      step();
      check_val($sformatf("t6_wait%0d", w), {PSEL, ACK0, ERR0}, 3'b100);
    end
    step();
    check_val("t6_abort",  {PSEL, PENABLE, ACK0, ERR0}, 4'b0011);
    check_val("t6_rdata0", RDATA0, 8'h5C);
    REQ0 = 1'b0;
    step();
    check_val("t6_err_clear", {ACK0, ERR0}, 0);
    REQ1 = 1'b1; WRITE1 = 1'b0; PRDATA = 8'h77; PREADY = 1'b1;
    step();
    step();
    step();
    check_val("t6_req1_ack", {ACK1, ERR1}, 2'b10);
    check_val("t6_rdata1",   RDATA1, 8'h77);
    REQ1 = 1'b0;
    step();
`else
    // Without the timeout, a stuck slave simply holds the bus.
    REQ0 = 1'b1; ADDR0 = 5'h04; WRITE0 = 1'b0; PREADY = 1'b0;
    step();
    step();
    for (int w = 0; w < 8; w++) step();
    check_val("t6_still_waiting", {PSEL, PENABLE, ACK0, ERR0}, 4'b1100);
    REQ0 = 1'b0;
    PRDATA = 8'h66; PREADY = 1'b1;
    step();
    check_val("t6_late_ack", {ACK0, ERR0}, 2'b10);
    check_val("t6_rdata0",   RDATA0, 8'h66);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
